sigdelay_prog: RTL and testbench
================================

// Module: sigdelay_prog
// PURPOSE
//  Parametrised successor to the fixed-offset signal delay: programmable-delay circular buffer with a
//  valid/ready sample interface, fill tracking (mutes output until the buffer holds real history) and
//  optional feedback echo. Sits between the mic/ADC sample source and the output DAC/scope path.
//  Internal simple-dual-port RAM (2**A_WIDTH x D_WIDTH, synchronous read), write pointer, fill counter, 2-state FSM.
// PARAMETERS
//  A_WIDTH   9   address width; buffer depth = 2**A_WIDTH samples; max delay = 2**A_WIDTH-1
//  D_WIDTH   8   sample width, two's-complement signed
//  FB_SHIFT  1   feedback attenuation = arithmetic right shift by FB_SHIFT (used only with ECHO_FEEDBACK_EN)
// PORTS
//  clk             in   1        clock, all logic rising-edge
//  rst             in   1        synchronous, active-high reset
//  en              in   1        global enable; low = no new samples accepted, in-flight sample completes
//  in_valid        in   1        mic_signal valid this cycle
//  in_ready        out  1        block can accept a sample this cycle
//  mic_signal      in   D_WIDTH  input sample (signed)
//  delay           in   A_WIDTH  requested delay in samples; sampled on accept
//  delayed_signal  out  D_WIDTH  delayed (or echoed) output sample, registered
//  out_valid       out  1        one-cycle pulse: delayed_signal updated
//  filled          out  1        high once delay_q samples written since last reset/delay change
// BEHAVIOUR
//  Reset: FSM=IDLE, wr_ptr=0, fill_cnt=0, delay_q=1, delayed_signal=0, out_valid=0, filled=0.
//  RAM contents not reset; stale data never reaches output (fill muting below).
//  in_ready = (state==IDLE) & en. Accept = in_valid & in_ready. At most one sample per 2 cycles.
//  FSM IDLE->BUSY on accept; BUSY->IDLE unconditionally next cycle. No other states.
//  Accept edge (T0): capture mic_signal -> din_q; d_eff = (delay==0)?1:delay; if d_eff!=delay_q:
//   delay_q<=d_eff, fill_cnt<=0; issue RAM read at rd_addr = wr_ptr - d_eff (mod 2**A_WIDTH, natural wrap).
//  BUSY edge (T1): rdata valid; tap = (fill_cnt>=delay_q) ? rdata : 0;
//   delayed_signal<=tap; out_valid<=1 (high during T2 only); RAM[wr_ptr]<=wdata; wr_ptr<=wr_ptr+1 (wraps);
//   fill_cnt<=min(fill_cnt+1, delay_q) (use the fill_cnt after any T0 clear, saturating).
//  Latency: accept at T0 -> out_valid high in cycle T0+2; next accept earliest T0+2.
//  filled = (fill_cnt==delay_q), registered state, no extra latency.
//  Read/write never collide: d_eff>=1 so rd_addr != wr_ptr; write happens the cycle after the read.
//  delay == 0 treated as 1 (never pass-through). delay changes ignored except on accept.
//  en low in BUSY: BUSY completes normally (write + out_valid); only new accepts blocked.
//  rst mid-operation (any state): everything returns to reset values next edge, in-flight write dropped.
// CONFIGURATION
//  ECHO_FEEDBACK_EN defined: wdata = sat(din_q + (tap >>> FB_SHIFT)), saturating to signed D_WIDTH
//   range [-2**(D_WIDTH-1), 2**(D_WIDTH-1)-1]; delayed_signal = tap as above (echo output).
//  ECHO_FEEDBACK_EN undefined: wdata = din_q; FB_SHIFT unused; pure delay line, no adder/saturator.
// TESTING
//  Reset then delay=3, feed 1,2,3,4,5 -> outputs 0,0,0,1,2; filled rises after 3rd write.
//  delay=0, feed 10,20 -> outputs 0,10 (treated as delay 1).
//  delay=4 running filled, switch delay=2 on next accept -> filled drops, 2 zero outputs, then x[n-2].
//  A_WIDTH=3, delay=7, feed 20 ramp samples -> output = x[n-7] across wr_ptr wraps, in_ready never low 2 cycles in row.
//  in_valid held high, en toggled low in BUSY -> that sample still yields out_valid; no accept until en=1.
//  ECHO_FEEDBACK_EN, D_WIDTH=8, FB_SHIFT=1, delay=1, feed 100 repeatedly -> outputs 0,100,127,127 (saturation); rst mid-BUSY -> out_valid stays 0.

Source files
------------

// File: rtl/sigdelay_prog.sv
// sigdelay_prog: programmable-delay circular buffer with valid/ready sample
// interface and fill muting. Optional feedback echo is enabled by defining
// ECHO_FEEDBACK_EN; without it the block is a pure delay line.
//
//  state | meaning
//  IDLE  | waiting for a sample; in_ready follows en
//  BUSY  | RAM read data valid; output updated, new sample written
module sigdelay_prog #(
  parameter int A_WIDTH  = 9,
  parameter int D_WIDTH  = 8,
  parameter int FB_SHIFT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [D_WIDTH-1:0] mic_signal,
  input  logic [A_WIDTH-1:0] delay,
  output logic [D_WIDTH-1:0] delayed_signal,
  output logic               out_valid,
  output logic               filled
);

  localparam int DEPTH = 1 << A_WIDTH;
  localparam logic [A_WIDTH-1:0] ONE_A = {{(A_WIDTH-1){1'b0}}, 1'b1};

  if (FB_SHIFT < 0 || FB_SHIFT >= D_WIDTH) begin : g_bad_fb_shift
    $error("sigdelay_prog: FB_SHIFT must be in [0, D_WIDTH-1]");
  end

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t             state;
  logic [D_WIDTH-1:0] mem [DEPTH];
  logic [D_WIDTH-1:0] rdata;
  logic [D_WIDTH-1:0] din_q;
  logic [D_WIDTH-1:0] tap;
  logic [D_WIDTH-1:0] wdata;
  logic [A_WIDTH-1:0] wr_ptr;
  logic [A_WIDTH-1:0] fill_cnt;
  logic [A_WIDTH-1:0] delay_q;
  logic [A_WIDTH-1:0] d_eff;
  logic [A_WIDTH-1:0] rd_addr;
  logic               accept;

  // Handshake, effective delay (zero never passes straight through) and read address
  assign in_ready = (state == IDLE) & en;
  assign accept   = in_valid & in_ready;
  assign d_eff    = (delay == '0) ? ONE_A : delay;
  assign rd_addr  = wr_ptr - d_eff;

  // Until the buffer holds delay_q real samples, the RAM word may be stale: mute it
  assign tap    = (fill_cnt >= delay_q) ? rdata : '0;
  assign filled = (fill_cnt == delay_q);

`ifdef ECHO_FEEDBACK_EN
  logic signed [D_WIDTH-1:0] fb;
  logic        [D_WIDTH:0]   sum;

  // Feed the attenuated tap back into the buffer, clamped to the signed sample range
  always_comb begin
    fb  = $signed(tap) >>> FB_SHIFT;
    sum = {din_q[D_WIDTH-1], din_q} + {fb[D_WIDTH-1], fb};
    if (sum[D_WIDTH] != sum[D_WIDTH-1]) begin
      wdata = sum[D_WIDTH] ? {1'b1, {(D_WIDTH-1){1'b0}}} : {1'b0, {(D_WIDTH-1){1'b1}}};
    end else begin
      wdata = sum[D_WIDTH-1:0];
    end
  end
`else
  assign wdata = din_q;
`endif

  // Synchronous RAM read, issued on the accept edge so data is ready in BUSY
  always_ff @(posedge clk) begin
    if (accept) begin
      rdata <= mem[rd_addr];
    end
  end

  // RAM write in BUSY; a reset in that cycle drops the in-flight write
  always_ff @(posedge clk) begin
    if (!rst && state == BUSY) begin
      mem[wr_ptr] <= wdata;
    end
  end

  // Control FSM: pointer, fill tracking, delay capture and registered output
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      fill_cnt       <= '0;
      delay_q        <= ONE_A;
      din_q          <= '0;
      delayed_signal <= '0;
      out_valid      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          out_valid <= 1'b0;
          if (accept) begin
            din_q <= mic_signal;
            state <= BUSY;
            if (d_eff != delay_q) begin
              delay_q  <= d_eff;
              fill_cnt <= '0;
            end
          end
        end
        BUSY: begin
          delayed_signal <= tap;
          out_valid      <= 1'b1;
          wr_ptr         <= wr_ptr + ONE_A;
          fill_cnt       <= (fill_cnt < delay_q) ? fill_cnt + ONE_A : delay_q;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sigdelay_prog.sv
// Bench for sigdelay_prog: one default-size instance and one A_WIDTH=3
// instance driven with identical stimulus and checked against the same
// hand-computed expectations (all delays used fit in 3 bits).
module tb_sigdelay_prog;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] mic = 8'd0;
  logic [8:0] dly = 9'd1;

  logic       rdy_b, ov_b, fl_b;
  logic [7:0] ds_b;
  logic       rdy_s, ov_s, fl_s;
  logic [7:0] ds_s;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sigdelay_prog #(.A_WIDTH(9), .D_WIDTH(8), .FB_SHIFT(1)) dut_big (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy_b),
    .mic_signal(mic), .delay(dly), .delayed_signal(ds_b), .out_valid(ov_b),
    .filled(fl_b)
  );

  sigdelay_prog #(.A_WIDTH(3), .D_WIDTH(8), .FB_SHIFT(1)) dut_small (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(rdy_s),
    .mic_signal(mic), .delay(dly[2:0]), .delayed_signal(ds_s), .out_valid(ov_s),
    .filled(fl_s)
  );

  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Offer one sample (bounded wait for ready), return the output seen after
  // the BUSY edge and whether out_valid was still high one cycle later.
  task automatic xfer(input logic [7:0] x, input logic [8:0] d,
                      output logic [7:0] ob, output logic [7:0] os,
                      output logic vb, output logic vs,
                      output logic fb, output logic fs,
                      output logic lingering);
    int n;
    n = 0;
    @(negedge clk);
    while (!(rdy_b && rdy_s) && n < 16) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    mic = x;
    dly = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    ob = ds_b; os = ds_s; vb = ov_b; vs = ov_s; fb = fl_b; fs = fl_s;
    @(posedge clk); #1;
    lingering = ov_b | ov_s;
  endtask

  task automatic test_reset;
    do_reset();
    #1;
    checks++;
    if (ds_b !== 8'd0 || ds_s !== 8'd0) begin
      failures++;
      $display("FAIL reset_delayed_signal big=%0d small=%0d exp=0", ds_b, ds_s);
    end
    checks++;
    if (ov_b !== 1'b0 || ov_s !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid big=%b small=%b exp=0", ov_b, ov_s);
    end
    checks++;
    if (fl_b !== 1'b0 || fl_s !== 1'b0) begin
      failures++;
      $display("FAIL reset_filled big=%b small=%b exp=0", fl_b, fl_s);
    end
    checks++;
    if (rdy_b !== 1'b1 || rdy_s !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready big=%b small=%b exp=1", rdy_b, rdy_s);
    end
  endtask

  task automatic test_delay3;
    logic [7:0] xs [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5};
    logic [7:0] ex [5] = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd2};
    logic       ef [5] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] ob, os;
    logic vb, vs, fb, fs, lg;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      xfer(xs[i], 9'd3, ob, os, vb, vs, fb, fs, lg);
      checks++;
      if (!vb || !vs || ob !== ex[i] || os !== ex[i]) begin
        failures++;
        $display("FAIL delay3_out[%0d] big=%0d/v%b small=%0d/v%b exp=%0d", i, ob, vb, os, vs, ex[i]);
      end
      checks++;
      if (fb !== ef[i] || fs !== ef[i]) begin
        failures++;
        $display("FAIL delay3_filled[%0d] big=%b small=%b exp=%b", i, fb, fs, ef[i]);
      end
      checks++;
      if (lg !== 1'b0) begin
        failures++;
        $display("FAIL delay3_pulse_width[%0d] out_valid still high got=%b exp=0", i, lg);
      end
    end
  endtask

  task automatic test_delay0;
    logic [7:0] xs [2] = '{8'd10, 8'd20};
    logic [7:0] ex [2] = '{8'd0, 8'd10};
    logic [7:0] ob, os;
    logic vb, vs, fb, fs, lg;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      xfer(xs[i], 9'd0, ob, os, vb, vs, fb, fs, lg);
      checks++;
      if (!vb || !vs || ob !== ex[i] || os !== ex[i]) begin
        failures++;
        $display("FAIL delay0_out[%0d] big=%0d/v%b small=%0d/v%b exp=%0d", i, ob, vb, os, vs, ex[i]);
      end
    end
  endtask

  task automatic test_delay_change;
    logic [7:0] xs [10] = '{8'd11, 8'd12, 8'd13, 8'd14, 8'd15, 8'd16, 8'd17, 8'd18, 8'd19, 8'd20};
    logic [8:0] ds [10] = '{9'd4, 9'd4, 9'd4, 9'd4, 9'd4, 9'd4, 9'd2, 9'd2, 9'd2, 9'd2};
    logic [7:0] ex [10] = '{8'd0, 8'd0, 8'd0, 8'd0, 8'd11, 8'd12, 8'd0, 8'd0, 8'd17, 8'd18};
    logic       ef [10] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [7:0] ob, os;
    logic vb, vs, fb, fs, lg;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      xfer(xs[i], ds[i], ob, os, vb, vs, fb, fs, lg);
      checks++;
      if (!vb || !vs || ob !== ex[i] || os !== ex[i]) begin
        failures++;
        $display("FAIL delay_change_out[%0d] big=%0d/v%b small=%0d/v%b exp=%0d", i, ob, vb, os, vs, ex[i]);
      end
      checks++;
      if (fb !== ef[i] || fs !== ef[i]) begin
        failures++;
        $display("FAIL delay_change_filled[%0d] big=%b small=%b exp=%b", i, fb, fs, ef[i]);
      end
    end
  endtask

  // in_valid held high: accepts every other cycle, small instance wraps its pointer
  task automatic test_back_to_back;
    int ready_low_twice;
    logic [7:0] exp;
    do_reset();
    ready_low_twice = 0;
    dly = 9'd7;
    mic = 8'd1;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (rdy_b !== 1'b0 || rdy_s !== 1'b0) ready_low_twice = ready_low_twice;
      @(negedge clk);
      if (rdy_b !== 1'b1 || rdy_s !== 1'b1) ready_low_twice++;
      exp = (i >= 7) ? 8'(i - 6) : 8'd0;
      checks++;
      if (ov_b !== 1'b1 || ov_s !== 1'b1 || ds_b !== exp || ds_s !== exp) begin
        failures++;
        $display("FAIL b2b_out[%0d] big=%0d/v%b small=%0d/v%b exp=%0d", i, ds_b, ov_b, ds_s, ov_s, exp);
      end
      if (i < 19) mic = 8'(i + 2);
      else in_valid = 1'b0;
    end
    checks++;
    if (ready_low_twice != 0) begin
      failures++;
      $display("FAIL b2b_in_ready_low_two_cycles count=%0d exp=0", ready_low_twice);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_en_toggle;
    int bad;
    do_reset();
    dly = 9'd1;
    mic = 8'd50;
    en = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    en = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ov_b !== 1'b1 || ov_s !== 1'b1 || ds_b !== 8'd0 || ds_s !== 8'd0) begin
      failures++;
      $display("FAIL en_low_busy_completes big=%0d/v%b small=%0d/v%b exp=0/v1", ds_b, ov_b, ds_s, ov_s);
    end
    checks++;
    if (rdy_b !== 1'b0 || rdy_s !== 1'b0) begin
      failures++;
      $display("FAIL en_low_in_ready big=%b small=%b exp=0", rdy_b, rdy_s);
    end
    bad = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (ov_b !== 1'b0 || ov_s !== 1'b0 || rdy_b !== 1'b0 || rdy_s !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL en_low_no_accept bad_cycles=%0d exp=0", bad);
    end
    mic = 8'd60;
    en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (ov_b !== 1'b1 || ov_s !== 1'b1 || ds_b !== 8'd50 || ds_s !== 8'd50) begin
      failures++;
      $display("FAIL en_resume_out big=%0d/v%b small=%0d/v%b exp=50/v1", ds_b, ov_b, ds_s, ov_s);
    end
  endtask

  task automatic test_echo_and_reset_busy;
`ifdef ECHO_FEEDBACK_EN
    logic [7:0] ex [4] = '{8'd0, 8'd100, 8'd127, 8'd127};
`else
    logic [7:0] ex [4] = '{8'd0, 8'd100, 8'd100, 8'd100};
`endif
    logic [7:0] ob, os;
    logic vb, vs, fb, fs, lg;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      xfer(8'd100, 9'd1, ob, os, vb, vs, fb, fs, lg);
      checks++;
      if (!vb || !vs || ob !== ex[i] || os !== ex[i]) begin
        failures++;
        $display("FAIL echo_out[%0d] big=%0d/v%b small=%0d/v%b exp=%0d", i, ob, vb, os, vs, ex[i]);
      end
    end
    @(negedge clk);
    in_valid = 1'b1;
    mic = 8'd100;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ov_b !== 1'b0 || ov_s !== 1'b0 || ds_b !== 8'd0 || ds_s !== 8'd0 || fl_b !== 1'b0 || fl_s !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_busy big=%0d/v%b/f%b small=%0d/v%b/f%b exp=0/v0/f0",
               ds_b, ov_b, fl_b, ds_s, ov_s, fl_s);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (ov_b !== 1'b0 || ov_s !== 1'b0 || rdy_b !== 1'b1 || rdy_s !== 1'b1) begin
      failures++;
      $display("FAIL rst_release_idle ov big=%b small=%b rdy big=%b small=%b exp ov=0 rdy=1",
               ov_b, ov_s, rdy_b, rdy_s);
    end
  endtask

  initial begin
    test_reset();
    test_delay3();
    test_delay0();
    test_delay_change();
    test_back_to_back();
    test_en_toggle();
    test_echo_and_reset_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
